// File: rtl/sized_fifo.sv
// sized_fifo: parameterised synchronous FIFO with guarded ready/enable handshakes.
// Ports:
//   clk, rst_n           - rising-edge clock, asynchronous active-low reset
//   enq_in/enq_en/enq_rdy - enqueue data, request, not-full
//   deq_out/deq_en/deq_rdy - head data (0 when empty), request, not-empty
//   clr_en               - synchronous clear, overrides enqueue/dequeue
//   count                - current occupancy
module sized_fifo #(
    parameter int width = 1,
    parameter int depth = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [width-1:0]           enq_in,
    input  logic                       enq_en,
    output logic                       enq_rdy,
    output logic [width-1:0]           deq_out,
    input  logic                       deq_en,
    output logic                       deq_rdy,
    input  logic                       clr_en,
    output logic [$clog2(depth+1)-1:0] count
);
    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    logic [width-1:0] mem [depth];
    logic [aw-1:0] head, tail;
    logic enq_fire, deq_fire;
    assign enq_rdy  = count != cw'(depth);
    assign deq_rdy  = count != '0;
    assign enq_fire = enq_en && enq_rdy;
    assign deq_fire = deq_en && deq_rdy;
    // Forced to zero when empty so the output never shows stale or X storage.
    assign deq_out  = deq_rdy ? mem[head] : '0;
    always_ff @(posedge clk)
        if (!clr_en && enq_fire) mem[tail] <= enq_in;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clr_en) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) tail <= tail + 1'b1;
            if (deq_fire) head <= head + 1'b1;
            count <= count + cw'(enq_fire) - cw'(deq_fire);
        end
endmodule

// File: tb/tb_sized_fifo.sv
// tb_sized_fifo: directed and scoreboard checks of sized_fifo at width=8, depth=4.
module tb_sized_fifo;
    logic clk = 0, rst_n = 1;
    logic [7:0] enq_in = 0, deq_out;
    logic enq_en = 0, deq_en = 0, clr_en = 0, enq_rdy, deq_rdy;
    logic [2:0] count;
    int checks = 0, errors = 0;

    sized_fifo #(.width(8), .depth(4)) dut (
        .clk(clk), .rst_n(rst_n), .enq_in(enq_in), .enq_en(enq_en), .enq_rdy(enq_rdy),
        .deq_out(deq_out), .deq_en(deq_en), .deq_rdy(deq_rdy), .clr_en(clr_en), .count(count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        checks++;
        if (count !== 3'd0 || enq_rdy !== 1'b1 || deq_rdy !== 1'b0 || deq_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_async count=%0d enq_rdy=%b deq_rdy=%b deq_out=%h required 0,1,0,00", count, enq_rdy, deq_rdy, deq_out);
        end
        #2;
        rst_n = 1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (count !== 3'd0 || enq_rdy !== 1'b1 || deq_rdy !== 1'b0 || deq_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle%0d count=%0d enq_rdy=%b deq_rdy=%b deq_out=%h required 0,1,0,00", i, count, enq_rdy, deq_rdy, deq_out);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            enq_in = v[i];
            enq_en = 1;
            cyc();
            checks++;
            if (count !== 3'(i + 1) || enq_rdy !== (i < 3)) begin
                errors++;
                $display("FAIL fill%0d count=%0d enq_rdy=%b required %0d,%b", i, count, enq_rdy, i + 1, i < 3);
            end
        end
        enq_in = 8'h55;
        cyc();
        enq_en = 0;
        checks++;
        if (count !== 3'd4 || enq_rdy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_ignored count=%0d enq_rdy=%b required 4,0", count, enq_rdy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (deq_out !== v[i]) begin
                errors++;
                $display("FAIL drain_data%0d got=%h required=%h", i, deq_out, v[i]);
            end
            deq_en = 1;
            cyc();
            checks++;
            if (count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL drain_count%0d got=%0d required=%0d", i, count, 3 - i);
            end
        end
        deq_en = 0;
        checks++;
        if (deq_rdy !== 1'b0 || deq_out !== 8'h00) begin
            errors++;
            $display("FAIL drained_empty deq_rdy=%b deq_out=%h required 0,00", deq_rdy, deq_out);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 2; i++) begin
            enq_in = 8'(8'h80 + i);
            enq_en = 1;
            cyc();
        end
        deq_en = 1;
        for (int i = 0; i < 10; i++) begin
            enq_in = 8'(8'h82 + i);
            checks++;
            if (deq_out !== 8'(8'h80 + i)) begin
                errors++;
                $display("FAIL stream_data%0d got=%h required=%h", i, deq_out, 8'(8'h80 + i));
            end
            cyc();
            checks++;
            if (count !== 3'd2) begin
                errors++;
                $display("FAIL stream_count%0d got=%0d required=2", i, count);
            end
        end
        enq_en = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (deq_out !== 8'(8'h8A + i)) begin
                errors++;
                $display("FAIL stream_tail%0d got=%h required=%h", i, deq_out, 8'(8'h8A + i));
            end
            cyc();
        end
        deq_en = 0;
        enq_en = 1;
        for (int i = 0; i < 4; i++) begin
            enq_in = 8'(8'hC0 + i);
            cyc();
        end
        enq_in = 8'hCC;
        deq_en = 1;
        cyc();
        enq_en = 0;
        checks++;
        if (count !== 3'd3 || enq_rdy !== 1'b1 || deq_out !== 8'hC1) begin
            errors++;
            $display("FAIL full_both count=%0d enq_rdy=%b deq_out=%h required 3,1,c1", count, enq_rdy, deq_out);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (deq_out !== 8'(8'hC0 + i)) begin
                errors++;
                $display("FAIL full_drain%0d got=%h required=%h", i, deq_out, 8'(8'hC0 + i));
            end
            cyc();
        end
        checks++;
        if (deq_rdy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL full_drain_empty deq_rdy=%b count=%0d required 0,0", deq_rdy, count);
        end
        enq_in = 8'hE7;
        enq_en = 1;
        cyc();
        enq_en = 0;
        checks++;
        if (count !== 3'd1 || deq_out !== 8'hE7) begin
            errors++;
            $display("FAIL empty_both count=%0d deq_out=%h required 1,e7", count, deq_out);
        end
        cyc();
        deq_en = 0;
    endtask

    task automatic test_clear();
        enq_en = 1;
        for (int i = 1; i <= 3; i++) begin
            enq_in = 8'(i);
            cyc();
        end
        enq_in = 8'hFF;
        deq_en = 1;
        clr_en = 1;
        cyc();
        clr_en = 0;
        deq_en = 0;
        checks++;
        if (count !== 3'd0 || deq_rdy !== 1'b0 || enq_rdy !== 1'b1 || deq_out !== 8'h00) begin
            errors++;
            $display("FAIL clear count=%0d deq_rdy=%b enq_rdy=%b deq_out=%h required 0,0,1,00", count, deq_rdy, enq_rdy, deq_out);
        end
        enq_in = 8'hA5;
        cyc();
        enq_en = 0;
        checks++;
        if (count !== 3'd1 || deq_out !== 8'hA5) begin
            errors++;
            $display("FAIL after_clear count=%0d deq_out=%h required 1,a5", count, deq_out);
        end
        deq_en = 1;
        cyc();
        deq_en = 0;
    endtask

    task automatic test_reset_midstream();
        enq_en = 1;
        enq_in = 8'h21;
        cyc();
        enq_in = 8'h22;
        cyc();
        enq_en = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (count !== 3'd0 || deq_rdy !== 1'b0 || enq_rdy !== 1'b1 || deq_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid count=%0d deq_rdy=%b enq_rdy=%b deq_out=%h required 0,0,1,00", count, deq_rdy, enq_rdy, deq_out);
        end
        rst_n = 1;
        enq_en = 1;
        enq_in = 8'h5A;
        cyc();
        enq_en = 0;
        checks++;
        if (count !== 3'd1 || deq_out !== 8'h5A) begin
            errors++;
            $display("FAIL reset_mid_enq count=%0d deq_out=%h required 1,5a", count, deq_out);
        end
        deq_en = 1;
        cyc();
        deq_en = 0;
        checks++;
        if (deq_rdy !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_drain deq_rdy=%b count=%0d required 0,0", deq_rdy, count);
        end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] exp_out;
        bit ef, df;
        for (int i = 0; i < 10000; i++) begin
            enq_en = 1'($urandom);
            deq_en = 1'($urandom);
            clr_en = $urandom_range(63) == 0;
            enq_in = 8'($urandom);
            exp_out = q.size() != 0 ? q[0] : 8'h00;
            checks++;
            if ($isunknown({count, enq_rdy, deq_rdy, deq_out}) || count !== 3'(q.size()) ||
                enq_rdy !== (q.size() != 4) || deq_rdy !== (q.size() != 0) || deq_out !== exp_out) begin
                errors++;
                $display("FAIL random%0d count=%0d enq_rdy=%b deq_rdy=%b deq_out=%h required %0d,%b,%b,%h",
                         i, count, enq_rdy, deq_rdy, deq_out, q.size(), q.size() != 4, q.size() != 0, exp_out);
            end
            ef = enq_en && q.size() != 4;
            df = deq_en && q.size() != 0;
            if (clr_en) q.delete();
            else begin
                if (df) void'(q.pop_front());
                if (ef) q.push_back(enq_in);
            end
            cyc();
        end
        enq_en = 0;
        deq_en = 0;
        clr_en = 0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_clear();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
